// File: rtl/cpu_control_fsm.sv
// Multicycle control FSM for the 16-bit CPU: fetch, decode, execute, memory, writeback.
// Define CTRL_HALT_EN to make instr 16'h0000 halt the machine (adds the halted output).
`timescale 1ns/1ps

module cpu_control_fsm #(
   parameter int IR_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IR_W-1:0] instr,
   input  logic            mem_rdy,
   input  logic            flag_z,
   input  logic            flag_c,
   input  logic            flag_f,
   input  logic            flag_n,
   input  logic            flag_l,
   output logic            ir_en,
   output logic            pc_en,
   output logic [1:0]      pc_src,
   output logic            addr_sel,
   output logic            mem_we,
   output logic            reg_we,
   output logic [1:0]      wb_sel,
   output logic            flags_en,
`ifdef CTRL_HALT_EN
   output logic            halted,
`endif
   output logic [2:0]      state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
`ifdef CTRL_HALT_EN
      , S_HALT = 3'd5
`endif
   } state_t;

   localparam logic [1:0] PC_INC  = 2'b00;
   localparam logic [1:0] PC_DISP = 2'b01;
   localparam logic [1:0] PC_REG  = 2'b10;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_LINK = 2'b10;

   state_t state_q, state_d;

   logic [3:0] opcode, cond, ext;
   logic       is_bcond, is_jcond, is_jal, is_load, is_stor, is_zero, is_cmp;
   logic       cond_ok;

   assign opcode = instr[15:12];
   assign cond   = instr[11:8];
   assign ext    = instr[7:4];

   assign is_bcond = (opcode == 4'hC);
   assign is_jcond = (opcode == 4'h4) && (ext == 4'hC);
   assign is_jal   = (opcode == 4'h4) && (ext == 4'h8);
   assign is_load  = (opcode == 4'h4) && (ext == 4'h0);
   assign is_stor  = (opcode == 4'h4) && (ext == 4'h4);
   assign is_zero  = (instr == '0);
   assign is_cmp   = ((opcode == 4'h0) && (ext == 4'hB)) || (opcode == 4'hB);

   always_comb begin
      case (cond)
         4'h0:    cond_ok = flag_z;
         4'h1:    cond_ok = !flag_z;
         4'h2:    cond_ok = flag_c;
         4'h3:    cond_ok = !flag_c;
         4'h4:    cond_ok = flag_l;
         4'h5:    cond_ok = !flag_l;
         4'h6:    cond_ok = flag_n;
         4'h7:    cond_ok = !flag_n;
         4'h8:    cond_ok = flag_f;
         4'h9:    cond_ok = !flag_f;
         4'hA:    cond_ok = !flag_l && !flag_z;
         4'hB:    cond_ok = flag_l || flag_z;
         4'hC:    cond_ok = !flag_n && !flag_z;
         4'hD:    cond_ok = flag_n || flag_z;
         4'hE:    cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // NOTE: state register uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   assign state = rst ? 3'd0 : state_q;

   // NOTE: every output is defaulted before the case so no path leaves a latch.
   always_comb begin
      state_d  = S_FETCH;
      ir_en    = 1'b0;
      pc_en    = 1'b0;
      pc_src   = PC_INC;
      addr_sel = 1'b0;
      mem_we   = 1'b0;
      reg_we   = 1'b0;
      wb_sel   = WB_ALU;
      flags_en = 1'b0;
`ifdef CTRL_HALT_EN
      halted   = 1'b0;
`endif
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               if (mem_rdy) begin
                  ir_en   = 1'b1;
                  state_d = S_DECODE;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
               if (is_bcond) begin
                  pc_en  = 1'b1;
                  pc_src = cond_ok ? PC_DISP : PC_INC;
               end else if (is_jcond) begin
                  pc_en  = 1'b1;
                  pc_src = cond_ok ? PC_REG : PC_INC;
               end else if (is_jal) begin
                  reg_we = 1'b1;
                  wb_sel = WB_LINK;
                  pc_en  = 1'b1;
                  pc_src = PC_REG;
               end else if (is_load || is_stor) begin
                  state_d = S_MEM;
               end else if (is_zero) begin
`ifdef CTRL_HALT_EN
                  state_d = S_HALT;
`else
                  pc_en = 1'b1;
`endif
               end else begin
                  reg_we   = !is_cmp;
                  flags_en = 1'b1;
                  pc_en    = 1'b1;
               end
            end
            S_MEM: begin
               addr_sel = 1'b1;
               mem_we   = is_stor;
               if (!mem_rdy)     state_d = S_MEM;
               else if (is_stor) pc_en   = 1'b1;
               else              state_d = S_WB;
            end
            S_WB: begin
               reg_we = 1'b1;
               wb_sel = WB_MEM;
               pc_en  = 1'b1;
            end
`ifdef CTRL_HALT_EN
            S_HALT: begin
               halted  = 1'b1;
               state_d = S_HALT;
            end
`endif
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule
